// File: rtl/boreal_dma_port_adapter.sv
// DMA engine to interconnect port adapter: request FIFO, CPU-priority issue, timeout.
// Optional macro BOREAL_DMA_PRIV_FILTER_EN rejects PRIV2-region heads locally.
`ifndef REGN_PRIV2
`define REGN_PRIV2 4'hE
`endif

module boreal_dma_port_adapter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_req_valid,
  output logic        in_req_ready,
  input  logic        in_req_we,
  input  logic [31:0] in_req_addr,
  input  logic [31:0] in_req_wdata,
  input  logic [3:0]  in_req_wstrb,
  output logic        in_resp_valid,
  output logic        in_resp_err,
  output logic [31:0] in_resp_rdata,
  output logic        dma_req_valid,
  output logic        dma_req_we,
  output logic [31:0] dma_req_addr,
  output logic [31:0] dma_req_wdata,
  output logic [3:0]  dma_req_wstrb,
  input  logic        dma_resp_valid,
  input  logic        dma_resp_err,
  input  logic [31:0] dma_resp_rdata,
  input  logic        cpu_req_valid,
  output logic [15:0] stat_starve,
  output logic [7:0]  stat_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW:0]   wp, rp;
  logic          full, empty, push, pop;
  logic          priv, issue, drop, tmo_hit;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rv_n, re_n;
  logic [31:0]   rd_n;

  // Extra pointer bit separates full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

`ifdef BOREAL_DMA_PRIV_FILTER_EN
  assign priv = !empty && (head.addr[31:28] == `REGN_PRIV2);
`else
  assign priv = 1'b0;
`endif

  assign in_req_ready  = !full;
  assign push          = in_req_valid && !full;
  assign dma_req_valid = (state == IDLE) && !empty && !priv;
  assign dma_req_we    = head.we;
  assign dma_req_addr  = head.addr;
  assign dma_req_wdata = head.wdata;
  assign dma_req_wstrb = head.wstrb;
  assign issue         = dma_req_valid && !cpu_req_valid;
  assign drop          = (state == IDLE) && priv;
  assign pop           = issue || drop;

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= '{in_req_we, in_req_addr,
                                   in_req_wdata, in_req_wstrb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rv_n    = 1'b0;
    rd_n    = in_resp_rdata;
    re_n    = in_resp_err;
    tmo_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (drop) begin
          rv_n = 1'b1;
          rd_n = '0;
          re_n = 1'b1;
        end else if (issue) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (dma_resp_valid) begin
          rv_n    = 1'b1;
          rd_n    = dma_resp_rdata;
          re_n    = dma_resp_err;
          state_n = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rv_n    = 1'b1;
          rd_n    = '0;
          re_n    = 1'b1;
          tmo_hit = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      in_resp_valid <= 1'b0;
      in_resp_err   <= 1'b0;
      in_resp_rdata <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      in_resp_valid <= rv_n;
      in_resp_err   <= re_n;
      in_resp_rdata <= rd_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_starve  <= '0;
      stat_timeout <= '0;
    end else begin
      if (dma_req_valid && cpu_req_valid && stat_starve != 16'hFFFF)
        stat_starve <= stat_starve + 1'b1;
      if (tmo_hit && stat_timeout != 8'hFF)
        stat_timeout <= stat_timeout + 1'b1;
    end
  end

endmodule

// File: tb/tb_boreal_dma_port_adapter.sv
// Directed and random checks of boreal_dma_port_adapter against a
// transaction-level queue model.
`ifndef REGN_PRIV2
`define REGN_PRIV2 4'hE
`endif

module tb_boreal_dma_port_adapter;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
`ifdef BOREAL_DMA_PRIV_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_req_valid, in_req_ready, in_req_we;
  logic [31:0] in_req_addr, in_req_wdata;
  logic [3:0]  in_req_wstrb;
  logic        in_resp_valid, in_resp_err;
  logic [31:0] in_resp_rdata;
  logic        dma_req_valid, dma_req_we;
  logic [31:0] dma_req_addr, dma_req_wdata;
  logic [3:0]  dma_req_wstrb;
  logic        dma_resp_valid, dma_resp_err;
  logic [31:0] dma_resp_rdata;
  logic        cpu_req_valid;
  logic [15:0] stat_starve;
  logic [7:0]  stat_timeout;

  boreal_dma_port_adapter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
    .in_req_we(in_req_we), .in_req_addr(in_req_addr),
    .in_req_wdata(in_req_wdata), .in_req_wstrb(in_req_wstrb),
    .in_resp_valid(in_resp_valid), .in_resp_err(in_resp_err),
    .in_resp_rdata(in_resp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_req_wstrb(dma_req_wstrb),
    .dma_resp_valid(dma_resp_valid), .dma_resp_err(dma_resp_err),
    .dma_resp_rdata(dma_resp_rdata),
    .cpu_req_valid(cpu_req_valid),
    .stat_starve(stat_starve), .stat_timeout(stat_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } rq_t;

  rq_t         mq[$];
  logic [31:0] issued[$];
  bit          m_wait, m_rv, m_re;
  int          m_ago, m_starve, m_tmo;
  logic [31:0] m_rd;
  int          n_err, n_chk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_priv(rq_t r);
    logic [3:0] nib;
    nib = r.addr[31:28];
    return FILTER && (nib == `REGN_PRIV2);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_wait = 0; m_rv = 0; m_re = 0; m_rd = '0;
    m_ago = 0; m_starve = 0; m_tmo = 0;
  endtask

  task automatic clr();
    in_req_valid = 0; in_req_we = 0; in_req_addr = '0;
    in_req_wdata = '0; in_req_wstrb = '0;
    dma_resp_valid = 0; dma_resp_err = 0; dma_resp_rdata = '0;
    cpu_req_valid = 0;
  endtask

  // Compare DUT with model, then advance the model across the coming edge.
  task automatic cyc();
    bit  exp_dv, push_ok;
    rq_t r;
    #1;
    exp_dv = !m_wait && mq.size() > 0 && !m_priv(mq[0]);
    chk("in_req_ready", in_req_ready, 32'(mq.size() < DEPTH));
    chk("dma_req_valid", dma_req_valid, 32'(exp_dv));
    if (exp_dv) begin
      chk("dma_req_addr", dma_req_addr, mq[0].addr);
      chk("dma_req_wdata", dma_req_wdata, mq[0].wdata);
      chk("dma_req_we_wstrb", {dma_req_we, dma_req_wstrb},
          {mq[0].we, mq[0].wstrb});
    end
    chk("in_resp_valid", in_resp_valid, 32'(m_rv));
    chk("in_resp_rdata", in_resp_rdata, m_rd);
    chk("in_resp_err", in_resp_err, 32'(m_re));
    chk("stat_starve", stat_starve, 32'(m_starve));
    chk("stat_timeout", stat_timeout, 32'(m_tmo));

    push_ok = in_req_valid && mq.size() < DEPTH;
    r = '{in_req_we, in_req_addr, in_req_wdata, in_req_wstrb};
    m_rv = 0;
    if (!m_wait) begin
      if (mq.size() > 0) begin
        if (m_priv(mq[0])) begin
          void'(mq.pop_front());
          m_rv = 1; m_rd = '0; m_re = 1;
        end else if (cpu_req_valid) begin
          if (m_starve < 65535) m_starve++;
        end else begin
          issued.push_back(mq[0].addr);
          void'(mq.pop_front());
          m_wait = 1; m_ago = 0;
        end
      end
    end else begin
      m_ago++;
      if (dma_resp_valid) begin
        m_rv = 1; m_rd = dma_resp_rdata; m_re = dma_resp_err;
        m_wait = 0;
      end else if (m_ago == TIMEOUT) begin
        m_rv = 1; m_rd = '0; m_re = 1; m_wait = 0;
        if (m_tmo < 255) m_tmo++;
      end
    end
    if (push_ok) mq.push_back(r);
    @(negedge clk);
  endtask

  task automatic push(logic [31:0] a, logic we, logic [31:0] d);
    in_req_valid = 1; in_req_addr = a; in_req_we = we;
    in_req_wdata = d; in_req_wstrb = 4'hF;
    cyc();
    in_req_valid = 0;
  endtask

  task automatic respond(logic [31:0] d, logic e);
    dma_resp_valid = 1; dma_resp_rdata = d; dma_resp_err = e;
    cyc();
    dma_resp_valid = 0; dma_resp_err = 0;
  endtask

  // Interconnect with fixed latency until the model is idle and empty.
  task automatic drain(int lat);
    int k;
    k = 0;
    while ((m_wait || mq.size() > 0 || m_rv) && k < 200) begin
      dma_resp_valid = m_wait && (m_ago == lat - 1);
      dma_resp_rdata = $urandom;
      cyc();
      k++;
    end
    dma_resp_valid = 0;
    chk("drain_bound", 32'(k < 200), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r_lat;
    n_err = 0; n_chk = 0;
    clr();
    m_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_req_ready, 32'd1);
    chk("rst_dv", dma_req_valid, 32'd0);
    chk("rst_resp", {in_resp_valid, in_resp_err}, 32'd0);
    chk("rst_rdata", in_resp_rdata, 32'd0);
    chk("rst_stats", {stat_starve, stat_timeout}, 32'd0);
    rst_n = 1;
    cyc();

    // Basic read, response sampled three edges after issue
    push(32'h0000_1010, 0, 32'h0);
    cyc();
    cyc(); cyc();
    respond(32'hDEADBEEF, 0);
    chk("r025_valid", in_resp_valid, 32'd1);
    chk("r025_rdata", in_resp_rdata, 32'hDEADBEEF);
    chk("r025_err", in_resp_err, 32'd0);
    cyc();
    chk("r025_pulse", in_resp_valid, 32'd0);

    // CPU starvation
    push(32'h0000_2000, 1, 32'h1234_5678);
    cpu_req_valid = 1;
    repeat (5) cyc();
    chk("r026_starve", stat_starve, 32'd5);
    cpu_req_valid = 0;
    chk("r026_issue_dv", dma_req_valid, 32'd1);
    cyc();
    cyc();
    respond(32'h0, 0);
    cyc();

    // Fill to full, reject extra push, drain in order
    cpu_req_valid = 1;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 0, 32'(i));
    chk("r027_full", in_req_ready, 32'd0);
    push(32'h0000_0BAD, 0, 32'h0);
    cpu_req_valid = 0;
    issued.delete();
    cyc();
    chk("r027_ready_pop", in_req_ready, 32'd1);
    drain(2);
    chk("r027_count", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      chk("r027_order", issued[i], 32'h100 + 32'(i * 4));

    // Timeout, then late response ignored
    push(32'h0000_3000, 0, 32'h0);
    cyc();
    k = 0;
    while (!in_resp_valid && k < 40) begin
      cyc();
      k++;
    end
    chk("r028_latency", 32'(k), 32'(TIMEOUT));
    chk("r028_err", in_resp_err, 32'd1);
    chk("r028_rdata", in_resp_rdata, 32'd0);
    chk("r028_tmo", stat_timeout, 32'd1);
    cyc(); cyc();
    respond(32'hCAFE_F00D, 0);
    chk("r028_late", in_resp_valid, 32'd0);
    cyc();

    // Reset while waiting
    push(32'h0000_4000, 0, 32'h0);
    cyc();
    cyc(); cyc();
    rst_n = 0;
    #1;
    chk("r029_dv", dma_req_valid, 32'd0);
    chk("r029_resp", {in_resp_valid, in_resp_err}, 32'd0);
    chk("r029_rdata", in_resp_rdata, 32'd0);
    chk("r029_stats", {stat_starve, stat_timeout}, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    respond(32'h5555_AAAA, 1);
    chk("r029_nopulse", in_resp_valid, 32'd0);
    chk("r029_empty", {in_req_ready, dma_req_valid}, 32'b10);
    cyc();

    // PRIV2 region head
    push(32'hE000_0040, 0, 32'h0);
    if (FILTER) begin
      cpu_req_valid = 1;
      chk("r030_dv", dma_req_valid, 32'd0);
      cyc();
      cpu_req_valid = 0;
      chk("r030_err", {in_resp_valid, in_resp_err}, 32'b11);
    end else begin
      chk("r030_dv", dma_req_valid, 32'd1);
      cyc();
      cyc();
      respond(32'h0000_1234, 1);
      chk("r030_err", {in_resp_valid, in_resp_err}, 32'b11);
      chk("r030_rdata", in_resp_rdata, 32'h0000_1234);
    end
    cyc();

    // Random traffic
    r_lat = 2;
    for (int i = 0; i < 600; i++) begin
      if (!m_wait) r_lat = $urandom_range(1, 18);
      in_req_valid   = ($urandom_range(0, 1) == 1);
      in_req_we      = $urandom_range(0, 1) == 1;
      in_req_addr    = $urandom;
      in_req_wdata   = $urandom;
      in_req_wstrb   = 4'($urandom);
      cpu_req_valid  = ($urandom_range(0, 2) == 0);
      dma_resp_valid = m_wait ? (m_ago == r_lat - 1)
                              : ($urandom_range(0, 7) == 0);
      dma_resp_rdata = $urandom;
      dma_resp_err   = ($urandom_range(0, 3) == 0);
      cyc();
    end
    clr();
    drain(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/boreal_dma_port_adapter.md
BOREAL_DMA_PORT_ADAPTER -- requirements
Module: boreal_dma_port_adapter

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles in WAIT before a local error response.
REQ-003 Ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 Ports: in_req_valid/in_req_ready/in_req_we  in/out/in  1; in_req_addr/in_req_wdata  in  32; in_req_wstrb  in  4  DMA engine request.
REQ-005 Ports: in_resp_valid/in_resp_err  out  1; in_resp_rdata  out  32  response to DMA engine.
REQ-006 Ports: dma_req_valid/dma_req_we  out  1; dma_req_addr/dma_req_wdata  out  32; dma_req_wstrb  out  4  request to interconnect DMA master port.
REQ-007 Ports: dma_resp_valid/dma_resp_err  in  1; dma_resp_rdata  in  32  interconnect response.
REQ-008 Ports: cpu_req_valid  in  1  CPU master request, observed only (CPU wins arbitration).
REQ-009 Ports: stat_starve  out  16  cycles blocked by CPU; stat_timeout  out  8  timed-out requests.

Function
REQ-010 FIFO SHALL accept a request when in_req_valid && in_req_ready; in_req_ready = FIFO not full; a full FIFO SHALL NOT accept, even if it pops in the same cycle.
REQ-011 FSM states: IDLE, WAIT; single outstanding request.
REQ-012 dma_req_valid SHALL be combinational: (state==IDLE) && FIFO non-empty; dma_req_* fields SHALL equal the FIFO head.
REQ-013 Issue SHALL occur on an edge where dma_req_valid && !cpu_req_valid: pop head, enter WAIT, clear wait counter.
REQ-014 On an edge where dma_req_valid && cpu_req_valid, head SHALL be held unchanged and stat_starve incremented, saturating at 0xFFFF.
REQ-015 In WAIT, dma_resp_valid SHALL register in_resp_valid=1 with rdata/err copied on the next edge, and return to IDLE.
REQ-016 In WAIT without a response, the counter SHALL increment; when it reaches TIMEOUT the block SHALL emit in_resp_valid=1, err=1, rdata=0, return to IDLE, and increment stat_timeout, saturating at 0xFF.
REQ-017 dma_resp_valid in IDLE, including late responses after a timeout, SHALL be discarded with no in_resp pulse.
REQ-018 in_resp_valid SHALL be a one-cycle pulse; in_resp_rdata/err SHALL hold until the next pulse.
REQ-019 Minimum issue-to-in_resp latency SHALL be 3 cycles: 2 in the interconnect plus 1 register; the next issue is allowed on the cycle after the in_resp pulse.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.

Reset
REQ-021 rst_n low SHALL asynchronously clear FIFO (empty), state=IDLE, wait counter, in_resp_valid/err/rdata=0, stat_starve=0, stat_timeout=0.
REQ-022 Reset during WAIT SHALL abandon the outstanding request; any later interconnect response SHALL be discarded per REQ-017.

Configuration
REQ-023 Macro BOREAL_DMA_PRIV_FILTER_EN defined: a head with addr[31:28]==`REGN_PRIV2 SHALL NOT be presented (dma_req_valid=0); it SHALL be popped in IDLE regardless of cpu_req_valid and answered on the next edge with err=1, rdata=0.
REQ-024 Macro undefined: PRIV addresses SHALL be forwarded like any other request, and the interconnect error SHALL be relayed.

Verification
REQ-025 Read at 0x0000_1010, cpu_req_valid=0, interconnect returns 0xDEADBEEF at issue+2 -> in_resp_valid at issue+3, rdata=0xDEADBEEF, err=0.
REQ-026 cpu_req_valid high 5 cycles while head pending -> no issue during those cycles, stat_starve=5, issue on the first cycle CPU is low.
REQ-027 Push 4 with no issue -> in_req_ready=0 after the 4th push; drain -> addresses issued in push order, ready=1 after the first pop.
REQ-028 Issue, no dma_resp_valid -> err pulse after 15 WAIT cycles, stat_timeout=1; a response arriving 3 cycles later -> no in_resp pulse.
REQ-029 rst_n low mid-WAIT, released, then interconnect response arrives -> all outputs 0, no in_resp pulse, FIFO empty.
REQ-030 With BOREAL_DMA_PRIV_FILTER_EN, push a `REGN_PRIV2 address -> dma_req_valid stays 0, in_resp err=1 one cycle after the pop; without the macro -> forwarded and the interconnect error is relayed.
